key_xor_stage: RTL and testbench
================================

Name: key_xor_stage

Overview:
Data-path stage paired with the 2-bit key counter. It holds a 4-entry byte key file and XORs each accepted payload byte with the key selected by the counter's key_count. It emits a one-cycle count_enable per accepted byte to advance the counter. It sits between the USB receive byte stream and the encrypted-output FIFO, with valid/ready on both sides and a one-deep output register.

Parameters:
DATA_W, 8, payload and key byte width
NUM_KEYS, 4, key file depth; fixed at 4 to match the 2-bit key_count
IDX_W, 2, key index width, equal to clog2(NUM_KEYS)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous, active-low reset
key_wr_en  input  1  key file write strobe
key_wr_addr  input  IDX_W  key file write index
key_wr_data  input  DATA_W  key byte to write
key_clear  input  1  invalidate all keys and return to LOAD
key_count  input  IDX_W  current key index from the key counter
count_enable  output  1  advance pulse to the key counter
in_valid  input  1  upstream byte valid
in_data  input  DATA_W  plaintext byte
in_ready  output  1  stage can accept a byte
out_valid  output  1  ciphertext byte valid
out_data  output  DATA_W  ciphertext byte
out_ready  input  1  downstream can accept
keys_ready  output  1  all NUM_KEYS entries written since the last clear
block_done  output  1  one-cycle pulse when the byte using key index NUM_KEYS-1 is accepted

Behaviour:
- Reset values: out_valid=0, out_data=0, keys_ready=0, block_done=0, count_enable=0; key file=0; loaded mask=0; state=LOAD.
- States:
  - LOAD: key writes allowed. Each write sets loaded_mask[key_wr_addr]. in_ready=0.
  - Transition LOAD->RUN on the edge after the mask reaches all-ones. keys_ready=1 in RUN.
  - RUN: key writes are ignored and the file is unchanged.
  - key_clear in RUN: next state is LOAD, mask=0, keys_ready=0, key bytes retained but unusable.
  - A byte held in out_data still drains normally after key_clear.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready). Combinational; must not depend on in_valid.
  - Accept = in_valid && in_ready.
  - On accept: out_data <= in_data ^ key[key_count], out_valid <= 1. One-cycle latency.
  - Output transfer = out_valid && out_ready. On transfer with no accept, out_valid <= 0. Transfer and accept in the same cycle keep out_valid=1 with the new data.
  - While out_valid=1 and out_ready=0, out_data holds stable.
- count_enable = accept. Combinational, exactly one cycle per accepted byte, never high otherwise. The counter updates on the same edge, so the next byte sees the next index.
- block_done: registered; high the cycle after an accept with key_count==NUM_KEYS-1.
- Simultaneous events:
  - key_wr_en and key_clear in the same cycle: key_clear wins and the write is dropped.
  - key_clear and accept in the same cycle: the accept completes and the state then goes to LOAD.
- Mid-operation reset: all state returns to reset values immediately and the held output byte is lost.

Optional Feature:
Macro KEY_XOR_PARITY_EN.
- Defined: adds output out_parity (1 bit), the even parity of out_data, registered alongside it. Reset value 0; stable under stall.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package key_pkg:
  - Constants: KEY_DATA_W=8, KEY_NUM=4, KEY_IDX_W=2.
  - typedef enum logic [0:0] key_xor_state_t {LOAD, RUN}.
  - typedef logic [KEY_DATA_W-1:0] key_byte_t.
- Sub-module key_reg_file:
  - 4 x DATA_W registers with write port and loaded mask.
  - Inputs: wr_en, wr_addr, wr_data, clear, lock.
  - Outputs: combinational read by index, all_loaded.
  - Async reset to zero.

Test Plan:
- Write keys 0x11,0x22,0x33,0x44 to addresses 0..3 -> keys_ready=1 one cycle after the 4th write; in_ready was 0 throughout LOAD.
- In RUN, key_count=0, send 0xA5 with out_ready=1 -> next cycle out_data=0xB4, out_valid=1; count_enable high exactly in the accept cycle.
- Stream 4 bytes 0x00 back-to-back while the bench counter steps key_count 0..3 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles; block_done pulses once after the 4th accept.
- Hold out_ready=0 with out_valid=1 -> in_ready=0, no count_enable, out_data stable for 5 cycles; out_ready=1 then drains it and accepts a new byte in the same cycle.
- Write 0xFF to address 2 during RUN -> ignored; a byte under key_count=2 still XORs with 0x33.
- Assert key_clear with key_wr_en together in RUN -> state LOAD, keys_ready=0, the write is dropped; n_rst asserted mid-stream -> out_valid=0 asynchronously.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and types for the key XOR data-path stage and its key file.
package key_pkg;

  localparam int KEY_DATA_W = 8;
  localparam int KEY_NUM    = 4;
  localparam int KEY_IDX_W  = 2;

  typedef enum logic [0:0] {
    LOAD,
    RUN
  } key_xor_state_t;

  typedef logic [KEY_DATA_W-1:0] key_byte_t;

endpackage

// File: rtl/key_reg_file.sv
// Four-entry key byte file with a per-entry loaded mask; writes blocked while locked.
module key_reg_file
  import key_pkg::*;
#(
  parameter int DATA_W   = KEY_DATA_W,
  parameter int NUM_KEYS = KEY_NUM,
  parameter int IDX_W    = KEY_IDX_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  input  logic              lock,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              all_loaded
);

  logic [DATA_W-1:0]   r_keys [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_mask;

  // NOTE: the key storage is reset along with the mask so a freshly reset file reads zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_keys <= '{default: '0};
      r_mask <= '0;
    end else if (clear) begin
      // Clear only invalidates; key bytes are retained but unusable until reloaded.
      r_mask <= '0;
    end else if (wr_en && !lock) begin
      r_keys[wr_addr] <= wr_data;
      r_mask[wr_addr] <= 1'b1;
    end
  end

  assign rd_data    = r_keys[rd_idx];
  assign all_loaded = &r_mask;

endmodule

// File: rtl/key_xor_stage.sv
// Key XOR stage: XORs accepted bytes with key[key_count], one-deep output register.
// Optional macro KEY_XOR_PARITY_EN adds out_parity, the even parity of out_data.
module key_xor_stage
  import key_pkg::*;
#(
  parameter int DATA_W   = KEY_DATA_W,
  parameter int NUM_KEYS = KEY_NUM,
  parameter int IDX_W    = KEY_IDX_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_addr,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              key_clear,
  input  logic [IDX_W-1:0]  key_count,
  output logic              count_enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              keys_ready,
`ifdef KEY_XOR_PARITY_EN
  output logic              out_parity,
  output logic              block_done
`else
  output logic              block_done
`endif
);

  key_xor_state_t    r_state;
  key_xor_state_t    w_state_next;
  logic              w_lock;
  logic              w_all_loaded;
  logic              w_accept;
  logic [DATA_W-1:0] w_key;
  logic [DATA_W-1:0] w_cipher;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_block_done;

  key_reg_file #(
    .DATA_W   (DATA_W),
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_key_reg_file (
    .clk        (clk),
    .n_rst      (n_rst),
    .wr_en      (key_wr_en),
    .wr_addr    (key_wr_addr),
    .wr_data    (key_wr_data),
    .clear      (key_clear),
    .lock       (w_lock),
    .rd_idx     (key_count),
    .rd_data    (w_key),
    .all_loaded (w_all_loaded)
  );

  // NOTE: non-blocking assignments make every register sample pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= LOAD;
    else        r_state <= w_state_next;
  end

  // NOTE: every output of this block is defaulted first so no latch can be inferred.
  always_comb begin
    w_state_next = r_state;
    w_lock       = 1'b0;
    keys_ready   = 1'b0;
    in_ready     = 1'b0;
    unique case (r_state)
      LOAD: begin
        if (!key_clear && w_all_loaded) w_state_next = RUN;
      end
      RUN: begin
        w_lock     = 1'b1;
        keys_ready = 1'b1;
        in_ready   = !r_out_valid || out_ready;
        if (key_clear) w_state_next = LOAD;
      end
      default: w_state_next = LOAD;
    endcase
    w_accept     = in_valid && in_ready;
    count_enable = w_accept;
  end

  assign w_cipher = in_data ^ w_key;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_block_done <= 1'b0;
    end else begin
      r_block_done <= w_accept && (key_count == IDX_W'(NUM_KEYS - 1));
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_cipher;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef KEY_XOR_PARITY_EN
  logic r_out_parity;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        r_out_parity <= 1'b0;
    else if (w_accept) r_out_parity <= ^w_cipher;
  end

  assign out_parity = r_out_parity;
`else
`endif

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign block_done = r_block_done;

endmodule

// File: tb/tb_key_xor_stage.sv
// Randomized self-checking bench for key_xor_stage against a queue-based reference model.
module tb_key_xor_stage;
  import key_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       key_wr_en;
  logic [1:0] key_wr_addr;
  key_byte_t  key_wr_data;
  logic       key_clear;
  logic [1:0] key_count;
  logic       count_enable;
  logic       in_valid;
  key_byte_t  in_data;
  logic       in_ready;
  logic       out_valid;
  key_byte_t  out_data;
  logic       out_ready;
  logic       keys_ready;
  logic       block_done;

  int         n_vec = 0;
  int         n_err = 0;
  key_byte_t  m_key [4];
  logic [1:0] kc;

  key_xor_stage dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .key_wr_en    (key_wr_en),
    .key_wr_addr  (key_wr_addr),
    .key_wr_data  (key_wr_data),
    .key_clear    (key_clear),
    .key_count    (key_count),
    .count_enable (count_enable),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .keys_ready   (keys_ready),
    .block_done   (block_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    key_wr_en   = 1'b0;
    key_wr_addr = '0;
    key_wr_data = '0;
    key_clear   = 1'b0;
    key_count   = kc;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
  endtask

  task automatic test_reset();
    kc    = '0;
    n_rst = 1'b0;
    idle_inputs();
    in_valid = 1'b1;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_vec++; if (keys_ready !== 1'b0) begin n_err++; $display("FAIL reset_keys_ready: got %b want 0", keys_ready); end
    n_vec++; if (block_done !== 1'b0) begin n_err++; $display("FAIL reset_block_done: got %b want 0", block_done); end
    n_vec++; if (count_enable !== 1'b0) begin n_err++; $display("FAIL reset_count_enable: got %b want 0", count_enable); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tick();
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) m_key[i] = '0;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_load();
    for (int i = 0; i < 4; i++) begin
      key_wr_en   = 1'b1;
      key_wr_addr = 2'(i);
      key_wr_data = 8'(8'h11 * (i + 1));
      in_valid    = 1'b1;
      in_data     = 8'($urandom);
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL load_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_vec++; if (count_enable !== 1'b0) begin n_err++; $display("FAIL load_count_enable[%0d]: got %b want 0", i, count_enable); end
      tick();
      m_key[i] = key_wr_data;
    end
    key_wr_en = 1'b0;
    in_valid  = 1'b0;
    #1;
    n_vec++; if (keys_ready !== 1'b0) begin n_err++; $display("FAIL load_keys_ready_early: got %b want 0", keys_ready); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL load_in_ready_early: got %b want 0", in_ready); end
    tick();
    n_vec++; if (keys_ready !== 1'b1) begin n_err++; $display("FAIL load_keys_ready: got %b want 1", keys_ready); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL run_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    kc        = 2'd0;
    key_count = kc;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b1;
    #1;
    n_vec++; if (count_enable !== 1'b1) begin n_err++; $display("FAIL single_count_enable: got %b want 1", count_enable); end
    tick();
    kc++;
    key_count = kc;
    in_valid  = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    n_vec++; if (out_data !== 8'hB4) begin n_err++; $display("FAIL single_out_data: got %h want b4", out_data); end
    n_vec++; if (count_enable !== 1'b0) begin n_err++; $display("FAIL single_count_enable_after: got %b want 0", count_enable); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    kc        = 2'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'h00;
      key_count = kc;
      #1;
      n_vec++; if (count_enable !== 1'b1) begin n_err++; $display("FAIL b2b_count_enable[%0d]: got %b want 1", i, count_enable); end
      tick();
      kc++;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_out_valid[%0d]: got %b want 1", i, out_valid); end
      n_vec++; if (out_data !== m_key[i]) begin n_err++; $display("FAIL b2b_out_data[%0d]: got %h want %h", i, out_data, m_key[i]); end
      n_vec++; if (block_done !== (i == 3)) begin n_err++; $display("FAIL b2b_block_done[%0d]: got %b want %b", i, block_done, i == 3); end
    end
    in_valid  = 1'b0;
    key_count = kc;
    tick();
    n_vec++; if (block_done !== 1'b0) begin n_err++; $display("FAIL b2b_block_done_pulse: got %b want 0", block_done); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    key_byte_t d1, d2, exp_hold, exp_new;
    d1        = 8'($urandom);
    d2        = 8'($urandom);
    key_count = kc;
    in_valid  = 1'b1;
    in_data   = d1;
    out_ready = 1'b0;
    tick();
    exp_hold  = d1 ^ m_key[kc];
    kc++;
    key_count = kc;
    in_data   = d2;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_vec++; if (count_enable !== 1'b0) begin n_err++; $display("FAIL stall_count_enable[%0d]: got %b want 0", i, count_enable); end
      tick();
      n_vec++; if (out_data !== exp_hold) begin n_err++; $display("FAIL stall_out_data[%0d]: got %h want %h", i, out_data, exp_hold); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid[%0d]: got %b want 1", i, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_in_ready: got %b want 1", in_ready); end
    n_vec++; if (count_enable !== 1'b1) begin n_err++; $display("FAIL stall_release_count_enable: got %b want 1", count_enable); end
    tick();
    exp_new = d2 ^ m_key[kc];
    kc++;
    key_count = kc;
    in_valid  = 1'b0;
    n_vec++; if (out_data !== exp_new) begin n_err++; $display("FAIL stall_new_data: got %h want %h", out_data, exp_new); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_new_valid: got %b want 1", out_valid); end
    tick();
  endtask

  task automatic test_random_stream();
    key_byte_t q[$];
    logic      exp_ready, exp_acc, exp_bd;
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      key_count = kc;
      #1;
      exp_ready = (q.size() == 0) || out_ready;
      exp_acc   = in_valid && exp_ready;
      n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL rand_in_ready[%0d]: got %b want %b", cyc, in_ready, exp_ready); end
      n_vec++; if (count_enable !== exp_acc) begin n_err++; $display("FAIL rand_count_enable[%0d]: got %b want %b", cyc, count_enable, exp_acc); end
      n_vec++; if (out_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rand_out_valid[%0d]: got %b want %b", cyc, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_vec++; if (out_data !== q[0]) begin n_err++; $display("FAIL rand_out_data[%0d]: got %h want %h", cyc, out_data, q[0]); end
        if (out_ready) void'(q.pop_front());
      end
      exp_bd = exp_acc && (kc == 2'd3);
      if (exp_acc) begin
        q.push_back(in_data ^ m_key[kc]);
        kc++;
      end
      tick();
      n_vec++; if (block_done !== exp_bd) begin n_err++; $display("FAIL rand_block_done[%0d]: got %b want %b", cyc, block_done, exp_bd); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    key_count = kc;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_run_write();
    key_byte_t d;
    key_wr_en   = 1'b1;
    key_wr_addr = 2'd2;
    key_wr_data = 8'hFF;
    tick();
    key_wr_en = 1'b0;
    d         = 8'($urandom);
    kc        = 2'd2;
    key_count = kc;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    tick();
    kc++;
    key_count = kc;
    in_valid  = 1'b0;
    n_vec++; if (out_data !== (d ^ 8'h33)) begin n_err++; $display("FAIL run_write_ignored: got %h want %h", out_data, d ^ 8'h33); end
    tick();
  endtask

  task automatic test_clear();
    key_byte_t d, exp;
    d           = 8'($urandom);
    key_count   = kc;
    in_valid    = 1'b1;
    in_data     = d;
    out_ready   = 1'b0;
    key_clear   = 1'b1;
    key_wr_en   = 1'b1;
    key_wr_addr = 2'd0;
    key_wr_data = 8'h99;
    #1;
    n_vec++; if (count_enable !== 1'b1) begin n_err++; $display("FAIL clear_accept: got %b want 1", count_enable); end
    tick();
    exp = d ^ m_key[kc];
    kc++;
    key_count = kc;
    in_valid  = 1'b0;
    // Clear again while already in LOAD, together with a write to entry 0.
    #1;
    n_vec++; if (keys_ready !== 1'b0) begin n_err++; $display("FAIL clear_keys_ready: got %b want 0", keys_ready); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL clear_in_ready: got %b want 0", in_ready); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL clear_hold_valid: got %b want 1", out_valid); end
    n_vec++; if (out_data !== exp) begin n_err++; $display("FAIL clear_hold_data: got %h want %h", out_data, exp); end
    out_ready = 1'b1;
    tick();
    key_clear = 1'b0;
    key_wr_en = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_drain: got %b want 0", out_valid); end
    for (int i = 1; i < 4; i++) begin
      key_wr_en   = 1'b1;
      key_wr_addr = 2'(i);
      key_wr_data = 8'($urandom);
      m_key[i]    = key_wr_data;
      tick();
    end
    key_wr_en = 1'b0;
    tick();
    tick();
    n_vec++; if (keys_ready !== 1'b0) begin n_err++; $display("FAIL clear_write_dropped: got %b want 0", keys_ready); end
    key_wr_en   = 1'b1;
    key_wr_addr = 2'd0;
    key_wr_data = 8'h55;
    m_key[0]    = 8'h55;
    tick();
    key_wr_en = 1'b0;
    tick();
    n_vec++; if (keys_ready !== 1'b1) begin n_err++; $display("FAIL reload_keys_ready: got %b want 1", keys_ready); end
    d         = 8'($urandom);
    kc        = 2'd0;
    key_count = kc;
    in_valid  = 1'b1;
    in_data   = d;
    tick();
    kc++;
    key_count = kc;
    in_valid  = 1'b0;
    n_vec++; if (out_data !== (d ^ 8'h55)) begin n_err++; $display("FAIL reload_out_data: got %h want %h", out_data, d ^ 8'h55); end
    tick();
  endtask

  task automatic test_async_reset();
    key_count = kc;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL async_out_data: got %h want 00", out_data); end
    n_vec++; if (keys_ready !== 1'b0) begin n_err++; $display("FAIL async_keys_ready: got %b want 0", keys_ready); end
    #1;
    n_rst     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    n_vec++; if (keys_ready !== 1'b0) begin n_err++; $display("FAIL async_stays_load: got %b want 0", keys_ready); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL async_in_ready: got %b want 0", in_ready); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_single();
    test_back_to_back();
    test_stall();
    test_random_stream();
    test_run_write();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
